// File: rtl/parte_ciaa_clk_pkg.sv
// Shared types and default constants for the PLL-downstream reset and timebase logic.
package parte_ciaa_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int unsigned LOSS_CNT_W             = 8;
    localparam int unsigned US_PER_S               = 1_000_000;
    localparam int unsigned DEF_CLK_HZ             = 50_000_000;
    localparam int unsigned DEF_TICK_MS_DIV        = 1000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_RST_HOLD_CYCLES    = 16;

    // Bits needed to count 0..limit-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/parte_ciaa_reset_gen_if.sv
// Lock input, loss-clear and reset/tick outputs of the reset generator.
interface parte_ciaa_reset_gen_if;
    import parte_ciaa_clk_pkg::*;

    logic                  LOCK;
    logic                  LOSS_CLR;
    logic                  SYS_RST;
    logic                  READY;
    logic                  TICK_US;
    logic                  TICK_MS;
    logic [LOSS_CNT_W-1:0] LOSS_CNT;

    modport master (
        output LOCK,
        output LOSS_CLR,
        input  SYS_RST,
        input  READY,
        input  TICK_US,
        input  TICK_MS,
        input  LOSS_CNT
    );

    modport slave (
        input  LOCK,
        input  LOSS_CLR,
        output SYS_RST,
        output READY,
        output TICK_US,
        output TICK_MS,
        output LOSS_CNT
    );

endinterface

// File: rtl/parte_ciaa_sync2.sv
// Generic two-flop synchronizer for asynchronous level inputs, with selectable reset value.
module parte_ciaa_sync2 #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/parte_ciaa_reset_gen.sv
// Lock qualification, system reset sequencing, lock-loss counting and 1 us / 1 ms tick strobes.
module parte_ciaa_reset_gen
    import parte_ciaa_clk_pkg::*;
#(
    parameter int unsigned CLK_HZ             = DEF_CLK_HZ,
    parameter int unsigned TICK_US_DIV        = CLK_HZ / US_PER_S,
    parameter int unsigned TICK_MS_DIV        = DEF_TICK_MS_DIV,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RESET,
    parte_ciaa_reset_gen_if.slave bus
);

    localparam int unsigned QUAL_LIMIT = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                         LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned QW = cnt_width(QUAL_LIMIT);
    localparam int unsigned UW = cnt_width(TICK_US_DIV);
    localparam int unsigned MW = cnt_width(TICK_MS_DIV);

    localparam logic [QW-1:0] STABLE_LAST = QW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [QW-1:0] HOLD_LAST   = QW'(RST_HOLD_CYCLES - 1);
    localparam logic [UW-1:0] US_LAST     = UW'(TICK_US_DIV - 1);
    localparam logic [MW-1:0] MS_LAST     = MW'(TICK_MS_DIV - 1);

    state_e                r_state;
    state_e                w_next_state;
    logic                  w_lock_s;
    logic [QW-1:0]         r_qual_cnt;
    logic [UW-1:0]         r_us_cnt;
    logic [MW-1:0]         r_ms_cnt;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic                  r_sys_rst;
    logic                  r_ready;
    logic                  r_tick_us;
    logic                  r_tick_ms;

    logic                  w_run_stay;
    logic                  w_loss_evt;
    logic                  w_us_hit;
    logic                  w_ms_hit;
    logic                  w_sys_rst_d;

    parte_ciaa_sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_d   (bus.LOCK),
        .o_q   (w_lock_s)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) w_next_state = STABLE;
            end
            STABLE: begin
                if (!w_lock_s)                       w_next_state = WAIT_LOCK;
                else if (r_qual_cnt == STABLE_LAST)  w_next_state = HOLD;
            end
            HOLD: begin
                if (!w_lock_s)                       w_next_state = WAIT_LOCK;
                else if (r_qual_cnt == HOLD_LAST)    w_next_state = RUN;
            end
            RUN: begin
                if (!w_lock_s) w_next_state = WAIT_LOCK;
            end
            default: w_next_state = WAIT_LOCK;
        endcase
    end

    // Registered outputs are computed from the next state so they change on the same edge as the FSM.
    always_comb begin
        w_run_stay  = (r_state == RUN) && (w_next_state == RUN);
        w_loss_evt  = (r_state == RUN) && !w_lock_s;
        w_us_hit    = (r_state == RUN) && (r_us_cnt == US_LAST);
        w_ms_hit    = w_us_hit && (r_ms_cnt == MS_LAST);
        w_sys_rst_d = (w_next_state != RUN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_qual_cnt <= '0;
        end else if ((w_next_state != r_state) ||
                     ((r_state != STABLE) && (r_state != HOLD))) begin
            r_qual_cnt <= '0;
        end else begin
            r_qual_cnt <= r_qual_cnt + QW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || !w_run_stay) begin
            r_us_cnt <= '0;
            r_ms_cnt <= '0;
        end else if (w_us_hit) begin
            r_us_cnt <= '0;
            r_ms_cnt <= w_ms_hit ? '0 : r_ms_cnt + MW'(1);
        end else begin
            r_us_cnt <= r_us_cnt + UW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_loss_cnt <= '0;
        end else if (bus.LOSS_CLR) begin
            r_loss_cnt <= w_loss_evt ? LOSS_CNT_W'(1) : '0;
        end else if (w_loss_evt && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_tick_us <= 1'b0;
            r_tick_ms <= 1'b0;
        end else begin
            r_sys_rst <= w_sys_rst_d;
            r_ready   <= !w_sys_rst_d;
            r_tick_us <= w_run_stay && w_us_hit;
            r_tick_ms <= w_run_stay && w_ms_hit;
        end
    end

    assign bus.SYS_RST  = r_sys_rst;
    assign bus.READY    = r_ready;
    assign bus.TICK_US  = r_tick_us;
    assign bus.TICK_MS  = r_tick_ms;
    assign bus.LOSS_CNT = r_loss_cnt;

endmodule
